// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the decimal LCD writer and its BCD converter.
package lcd_fmt_pkg;

  localparam int DIN_W      = 32;
  localparam int NUM_DIGITS = 10;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(DIN_W);

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Sequencer states; ST_IDLE is the all-zero reset encoding.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_CLEAR,
    ST_CLR_GAP,
    ST_EMIT,
    ST_EMIT_GAP,
    ST_FINISH
  } state_e;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the most significant non-zero digit; 0 when the value is zero,
  // so a zero value still shows a single '0'.
  function automatic logic [3:0] top_digit_idx(input logic [BCD_W-1:0] bcd);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) idx = 4'(i);
    end
    return idx;
  endfunction

  // One BCD digit selected by index (0 = least significant).
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd, input logic [3:0] idx);
    return bcd[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter: one shift per cycle, DIN_W cycles per value.
// done is high during the final shift cycle; bcd holds the result from the next
// cycle until the following start.
module bcd_double_dabble
  import lcd_fmt_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIN_W-1:0] din,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [DIN_W-1:0] bin_q,  bin_d;
  logic [BCD_W-1:0] bcd_q,  bcd_d;
  logic [BCD_W-1:0] adj;

  assign adj = dd_adjust(bcd_q);

  // Next-state: load on start, otherwise correct-and-shift while busy.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned, which would infer a latch.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    if (busy_q) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[DIN_W-1]};
      bin_d = {bin_q[DIN_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DIN_W - 1)) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      bin_d  = din;
      bcd_d  = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(DIN_W - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_decimal_writer.sv
// Converts a 32-bit value to decimal and paces it out to a character LCD:
// one clear pulse, then one strobe per digit, each followed by GAP_CYCLES idle cycles.
module lcd_decimal_writer
  import lcd_fmt_pkg::*;
#(
  parameter int GAP_CYCLES    = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             lcd_reset,
  output logic             lcd_write_en,
  output logic [7:0]       lcd_write_data
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] gap_q,   gap_d;
  logic [3:0] idx_q,   idx_d;
  logic [7:0] wdata_q, wdata_d;

  logic             accept;
  logic             dd_done;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       first_idx;
  logic [3:0]       nxt_idx;

  // A new value is taken only when idle or in the one-cycle finish state.
  assign accept = start && (state_q == ST_IDLE || state_q == ST_FINISH);

  bcd_double_dabble u_dd (
    .clock (clock),
    .reset (reset),
    .start (accept),
    .din   (value),
    .done  (dd_done),
    .bcd   (bcd)
  );

  assign first_idx = BLANK_LEADING ? top_digit_idx(bcd) : 4'(NUM_DIGITS - 1);
  assign nxt_idx   = idx_q - 4'd1;

  // Sequencer next-state: conversion, clear, then digit strobes with gaps.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (dd_done) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_CLR_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_CLR_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_EMIT;
          idx_d   = first_idx;
          wdata_d = ASCII_ZERO + {4'h0, digit_at(bcd, first_idx)};
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_EMIT: begin
        state_d = ST_EMIT_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_EMIT_GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (idx_q == 4'd0) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_EMIT;
          idx_d   = nxt_idx;
          wdata_d = ASCII_ZERO + {4'h0, digit_at(bcd, nxt_idx)};
        end
      end
      ST_FINISH: begin
        state_d = accept ? ST_CONVERT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; write data is loaded on entry to EMIT and held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy           = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done           = (state_q == ST_FINISH);
  assign lcd_reset      = (state_q == ST_CLEAR);
  assign lcd_write_en   = (state_q == ST_EMIT);
  assign lcd_write_data = wdata_q;

endmodule

// File: tb/tb_lcd_decimal_writer.sv
// Bench for lcd_decimal_writer: instance 0 blanks leading zeros (gap 4),
// instance 1 shows all ten digits (gap 3).
module tb_lcd_decimal_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_s [2];
  logic [31:0] value_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        lrst_s  [2];
  logic        wen_s   [2];
  logic [7:0]  wd_s    [2];

  always #5 clock = ~clock;

  lcd_decimal_writer #(.GAP_CYCLES(4), .BLANK_LEADING(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start_s[0]), .value(value_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .lcd_reset(lrst_s[0]),
    .lcd_write_en(wen_s[0]), .lcd_write_data(wd_s[0])
  );

  lcd_decimal_writer #(.GAP_CYCLES(3), .BLANK_LEADING(1'b0)) dut_full (
    .clock(clock), .reset(reset), .start(start_s[1]), .value(value_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .lcd_reset(lrst_s[1]),
    .lcd_write_en(wen_s[1]), .lcd_write_data(wd_s[1])
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event log per instance, sampled mid-cycle.
  int  str_cyc  [2][$];
  byte str_dat  [2][$];
  int  rst_cyc  [2][$];
  int  done_cyc [2][$];
  int  overlap_err   [2];
  int  done_busy_err [2];

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (wen_s[d]) begin
        str_cyc[d].push_back(cyc);
        str_dat[d].push_back(wd_s[d]);
      end
      if (lrst_s[d]) rst_cyc[d].push_back(cyc);
      if (done_s[d]) begin
        done_cyc[d].push_back(cyc);
        if (busy_s[d]) done_busy_err[d]++;
      end
      if (wen_s[d] && lrst_s[d]) overlap_err[d]++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Reference: decimal text of v, optionally without leading zeros.
  function automatic string to_dec(input logic [31:0] v, input bit blank);
    longint x;
    int     digs [10];
    string  s;
    bit     started;
    x = v;
    s = "";
    for (int i = 0; i < 10; i++) begin
      digs[i] = int'(x % 10);
      x = x / 10;
    end
    started = !blank;
    for (int i = 9; i >= 0; i--) begin
      if (digs[i] != 0 || i == 0) started = 1'b1;
      if (started) s = {s, $sformatf("%0d", digs[i])};
    end
    return s;
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_log(input int d);
    str_cyc[d].delete();
    str_dat[d].delete();
    rst_cyc[d].delete();
    done_cyc[d].delete();
  endtask

  // Pulse start for one cycle; k is the cycle in which start is sampled.
  task automatic launch(input int d, input logic [31:0] v, output int k);
    step();
    check("busy_before_start", busy_s[d], 0);
    clear_log(d);
    start_s[d] = 1'b1;
    value_s[d] = v;
    k = cyc;
    step();
    start_s[d] = 1'b0;
    value_s[d] = $urandom;
    check("busy_after_start", busy_s[d], 1);
  endtask

  task automatic wait_done(input int d, input string tag);
    int n;
    n = 0;
    while (done_cyc[d].size() == 0 && n < 3000) begin
      step();
      n++;
    end
    check({tag, "/done_seen"}, done_cyc[d].size() > 0, 1);
  endtask

  task automatic wait_strobes(input int d, input int cnt, input string tag);
    int n;
    n = 0;
    while (str_cyc[d].size() < cnt && n < 3000) begin
      step();
      n++;
    end
    check({tag, "/strobes_seen"}, str_cyc[d].size() >= cnt, 1);
  endtask

  // Compare the logged sequence against the expected text and timing.
  task automatic compare(input int d, input int k, input string exp, input string tag);
    int g, n, first;
    g = gap_of(d);
    n = exp.len();
    first = k + 34 + g;
    check({tag, "/lcd_reset_count"}, rst_cyc[d].size(), 1);
    if (rst_cyc[d].size() > 0) check({tag, "/lcd_reset_cycle"}, rst_cyc[d][0] - k, 33);
    check({tag, "/strobe_count"}, str_cyc[d].size(), n);
    for (int i = 0; i < n && i < str_cyc[d].size(); i++) begin
      check({tag, $sformatf("/char%0d", i)}, str_dat[d][i], exp[i]);
      check({tag, $sformatf("/cycle%0d", i)}, str_cyc[d][i] - k, first + i * (g + 1) - k);
    end
    check({tag, "/done_count"}, done_cyc[d].size(), 1);
    if (done_cyc[d].size() > 0)
      check({tag, "/done_cycle"}, done_cyc[d][0] - k, first + (n - 1) * (g + 1) + g + 1 - k);
    check({tag, "/data_hold"}, wd_s[d], exp[n-1]);
    check({tag, "/no_overlap"}, overlap_err[d], 0);
    check({tag, "/done_not_busy"}, done_busy_err[d], 0);
  endtask

  typedef struct {
    int          d;
    logic [31:0] value;
    string       exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int k, k2, d, n;
    logic [31:0] v;

    reset      = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    value_s[0] = '0;
    value_s[1] = '0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", busy_s[i], 0);
      check("reset_done", done_s[i], 0);
      check("reset_lcd_reset", lrst_s[i], 0);
      check("reset_write_en", wen_s[i], 0);
      check("reset_write_data", wd_s[i], 0);
    end
    reset = 1'b0;
    repeat (2) step();

    vecs[0] = '{0, 32'd56876,      "56876"};
    vecs[1] = '{0, 32'd0,          "0"};
    vecs[2] = '{0, 32'hFFFF_FFFF,  "4294967295"};
    vecs[3] = '{1, 32'd7,          "0000000007"};
    vecs[4] = '{1, 32'd0,          "0000000000"};
    vecs[5] = '{0, 32'd1000000000, "1000000000"};

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].d, vecs[i].value, k);
      wait_done(vecs[i].d, $sformatf("vec%0d", i));
      compare(vecs[i].d, k, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 8; r++) begin
      d = int'($urandom_range(0, 1));
      v = $urandom >> $urandom_range(0, 31);
      launch(d, v, k);
      wait_done(d, $sformatf("rand%0d", r));
      compare(d, k, to_dec(v, d == 0), $sformatf("rand%0d_v%0d", r, v));
    end

    // start during a character gap must not disturb the running sequence
    launch(0, 32'd56876, k);
    wait_strobes(0, 2, "ignore");
    step();
    start_s[0] = 1'b1;
    value_s[0] = 32'd99;
    step();
    start_s[0] = 1'b0;
    check("ignore/busy_held", busy_s[0], 1);
    wait_done(0, "ignore");
    compare(0, k, "56876", "ignore");

    // asynchronous reset after the third strobe aborts the sequence
    launch(0, 32'd56876, k);
    wait_strobes(0, 3, "abort");
    step();
    #1 reset = 1'b1;
    #1;
    check("abort/busy", busy_s[0], 0);
    check("abort/done", done_s[0], 0);
    check("abort/lcd_reset", lrst_s[0], 0);
    check("abort/write_en", wen_s[0], 0);
    check("abort/write_data", wd_s[0], 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (100) step();
    check("abort/no_more_strobes", str_cyc[0].size(), 3);
    check("abort/no_done", done_cyc[0].size(), 0);
    launch(0, 32'd12, k);
    wait_done(0, "after_abort");
    compare(0, k, "12", "after_abort");

    // start held through the done cycle is taken there with the new value
    launch(0, 32'd12, k);
    start_s[0] = 1'b1;
    value_s[0] = 32'd5;
    n = 0;
    while (!done_s[0] && n < 3000) begin
      step();
      n++;
    end
    check("chain/done_seen", done_s[0], 1);
    k2 = cyc;
    compare(0, k, "12", "chain_first");
    step();
    start_s[0] = 1'b0;
    check("chain/busy_next_cycle", busy_s[0], 1);
    clear_log(0);
    wait_done(0, "chain_second");
    compare(0, k2, "5", "chain_second");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_decimal_writer.md
LCD_DECIMAL_WRITER -- requirements
Module: lcd_decimal_writer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, idle cycles after every lcd_reset/lcd_write_en pulse (legal 1..255).
REQ-002 SHALL have parameter BLANK_LEADING, default 1, 1 = suppress leading zeros.
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to display value; sampled only when busy=0.
REQ-006 SHALL have port value  input  32  unsigned binary number, latched on accepted start.
REQ-007 SHALL have port busy  output  1  high from cycle after accepted start until done cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse after last character gap.
REQ-009 SHALL have port lcd_reset  output  1  one-cycle display-clear pulse to lcd controller.
REQ-010 SHALL have port lcd_write_en  output  1  one-cycle character strobe to lcd controller.
REQ-011 SHALL have port lcd_write_data  output  8  ASCII character, valid when lcd_write_en=1.

Function
REQ-012 SHALL accept start only in IDLE or in the done cycle; start while busy=1 SHALL be ignored with no side effect.
REQ-013 SHALL run FSM IDLE -> CONVERT -> CLEAR -> CLR_GAP -> EMIT -> EMIT_GAP -> (EMIT | FINISH) -> IDLE.
REQ-014 CONVERT SHALL perform iterative double-dabble, one bit per cycle, exactly 32 cycles, yielding 10 BCD digits (40 bits).
REQ-015 Double-dabble SHALL add 3 to each BCD nibble >= 5 before each shift; no divider or multiplier SHALL be used.
REQ-016 CLEAR SHALL last 1 cycle with lcd_reset=1; CLR_GAP SHALL last GAP_CYCLES cycles.
REQ-017 EMIT SHALL last 1 cycle with lcd_write_en=1, lcd_write_data=8'h30+digit, most-significant displayed digit first.
REQ-018 EMIT_GAP SHALL last GAP_CYCLES cycles, then go to EMIT for next digit or FINISH after digit 0.
REQ-019 With BLANK_LEADING=1, leading zero digits SHALL be skipped (no strobe, no gap); value 0 SHALL emit exactly one '0'.
REQ-020 With BLANK_LEADING=0, all 10 digits SHALL be emitted.
REQ-021 FINISH SHALL last 1 cycle with done=1, busy=0, then IDLE.
REQ-022 Timing: start accepted at edge k -> busy=1 at k+1, lcd_reset at k+33, first strobe at k+34+GAP_CYCLES, subsequent strobes every GAP_CYCLES+1 cycles.
REQ-023 lcd_reset and lcd_write_en SHALL never be high in the same cycle.
REQ-024 lcd_write_data SHALL hold its last value when lcd_write_en=0.

Reset
REQ-025 reset SHALL asynchronously force IDLE, busy=0, done=0, lcd_reset=0, lcd_write_en=0, lcd_write_data=8'h00, counters and BCD register to 0.
REQ-026 Reset mid-operation SHALL abort with no further strobes; next start after release SHALL behave as from power-up.

Structure
REQ-027 Shared package lcd_fmt_pkg SHALL hold FSM state encoding, ASCII_ZERO=8'h30, NUM_DIGITS=10, DIN_W=32.
REQ-028 SHALL instantiate one sub-module bcd_double_dabble (start/done handshake, 32-bit in, 40-bit BCD out); sequencing/pacing stays in the top.

Verification
REQ-029 GAP_CYCLES=4, BLANK_LEADING=1, value=56876 -> one lcd_reset, then strobes 0x35,0x36,0x38,0x37,0x36 spaced 5 cycles, done once, first strobe at k+38.
REQ-030 value=0 -> one strobe 0x30; value=32'hFFFFFFFF -> 10 strobes "4294967295".
REQ-031 BLANK_LEADING=0, value=7 -> strobes "0000000007" (nine 0x30 then 0x37).
REQ-032 start pulsed during EMIT_GAP with value=99 -> ignored, original digits complete unchanged.
REQ-033 reset asserted after 3rd strobe of 56876 -> all outputs 0 same cycle, no more strobes; new start value=12 -> "12" correctly.
REQ-034 start held high through done cycle with new value=5 -> accepted in done cycle, second sequence begins at next edge.
